// File: rtl/led_chaser_pkg.sv
// Shared types and constants for the LED chaser sequencer.
//   state_e   : sequencer FSM states
//   avm_wr_t  : Avalon-MM write payload (address + data)
//   step_t    : LED position plus travel direction
//   next_step : position/direction update for wrap and ping-pong modes
package led_chaser_pkg;

  localparam int unsigned LED_W      = 8;
  localparam int unsigned POS_W      = 3;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned AVM_ADDR_W = 3;
  localparam int unsigned AVM_DATA_W = 32;

  localparam logic [AVM_ADDR_W-1:0] PIO_ADDR_DATA = 3'd0;
  localparam logic [AVM_ADDR_W-1:0] PIO_ADDR_SET  = 3'd4;
  localparam logic [AVM_ADDR_W-1:0] PIO_ADDR_CLR  = 3'd5;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_INIT,
    ST_RUN,
    ST_WR_STEP,
    ST_WR_CLEAR
  } state_e;

  typedef struct packed {
    logic [AVM_ADDR_W-1:0] addr;
    logic [AVM_DATA_W-1:0] data;
  } avm_wr_t;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             dir;
  } step_t;

  // Ping-pong reverses on the endpoint itself, so 7 and 0 are never repeated.
  function automatic step_t next_step(input logic [POS_W-1:0] pos,
                                      input logic             dir,
                                      input logic             bnc);
    step_t s;
    s.pos = pos + POS_W'(1);
    s.dir = dir;
    if (bnc) begin
      if (dir == DIR_UP) begin
        if (pos == POS_W'(LED_W - 1)) begin
          s.pos = pos - POS_W'(1);
          s.dir = DIR_DN;
        end
      end else begin
        if (pos == '0) begin
          s.pos = POS_W'(1);
          s.dir = DIR_UP;
        end else begin
          s.pos = pos - POS_W'(1);
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/led_chaser_tick.sv
// Step timer: loadable 32-bit down-counter that saturates at zero.
//   i_clr      : synchronous clear (wins over load)
//   i_load     : load i_load_val
//   i_en       : count enable
//   o_tc_c     : terminal count, high while enabled and the count is zero
module led_chaser_tick
  import led_chaser_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc_c = i_en && (r_count == '0);

endmodule

// File: rtl/led_chaser_ctrl.sv
// Running-light sequencer; sole Avalon-MM write master of the 8-bit LED PIO.
//   start/stop      : start on rising edge, stop while high (stop wins)
//   speed           : step period = TICK_CYCLES << speed
//   bounce          : 1 = ping-pong, 0 = wrap
//   avm_*           : Avalon-MM write master toward the PIO slave
//   busy            : high outside IDLE
//   pos             : index of the lit LED
module led_chaser_ctrl #(
  parameter int unsigned TICK_CYCLES = 5_000_000,
  parameter int unsigned LED_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  speed,
  input  logic        bounce,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [2:0]  pos
);
  import led_chaser_pkg::*;

  localparam logic [LED_W-1:0] LED_ALL = '1;

  state_e           r_state, w_state_nxt;
  logic             r_start_d;
  logic             r_cs, w_cs_nxt;
  logic             r_write_n;
  avm_wr_t          r_wr, w_wr_nxt;
  logic             r_busy;
  logic [POS_W-1:0] r_pos, w_pos_nxt;
  logic             r_dir, w_dir_nxt;
  step_t            r_step, w_step_nxt;

  logic             w_start_rise;
  logic             w_tick_load;
  logic             w_tick_clr;
  logic             w_tick_en;
  logic             w_tick_tc;
  logic [CNT_W-1:0] w_tick_load_val;
  logic [LED_W-1:0] w_onehot;

  assign w_start_rise    = start & ~r_start_d;
  assign w_tick_en       = (r_state == ST_RUN);
  // speed is sampled when the interval is loaded, i.e. once per step
  assign w_tick_load_val = (CNT_W'(TICK_CYCLES) << speed) - CNT_W'(1);
  assign w_onehot        = LED_W'(1) << r_step.pos;

  led_chaser_tick u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (w_tick_clr),
    .i_load     (w_tick_load),
    .i_load_val (w_tick_load_val),
    .i_en       (w_tick_en),
    .o_tc_c     (w_tick_tc)
  );

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_start_d <= 1'b0;
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      r_wr      <= '0;
      r_busy    <= 1'b0;
      r_pos     <= '0;
      r_dir     <= DIR_UP;
      r_step    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= start;
      r_cs      <= w_cs_nxt;
      r_write_n <= ~w_cs_nxt;
      r_wr      <= w_wr_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_step    <= w_step_nxt;
    end
  end

  // Next-state and write-master control; each WR_* state raises the strobe
  // on its first cycle and leaves once the slave accepts it.
  always_comb begin
    w_state_nxt = r_state;
    w_cs_nxt    = r_cs;
    w_wr_nxt    = r_wr;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_step_nxt  = r_step;
    w_tick_load = 1'b0;
    w_tick_clr  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start_rise && !stop) begin
          w_state_nxt = ST_WR_INIT;
          w_pos_nxt   = '0;
          w_dir_nxt   = DIR_UP;
        end
      end

      ST_WR_INIT: begin
        if (r_cs) begin
          if (!avm_waitrequest) begin
            w_cs_nxt = 1'b0;
            if (stop) begin
              w_state_nxt = ST_WR_CLEAR;
            end else begin
              w_state_nxt = ST_RUN;
              w_tick_load = 1'b1;
            end
          end
        end else if (stop) begin
          w_state_nxt = ST_WR_CLEAR;
        end else begin
          w_cs_nxt      = 1'b1;
          w_wr_nxt.addr = PIO_ADDR_DATA;
          w_wr_nxt.data = AVM_DATA_W'(LED_W'(1));
        end
      end

      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_WR_CLEAR;
          w_tick_clr  = 1'b1;
        end else if (w_tick_tc) begin
          w_step_nxt  = next_step(r_pos, r_dir, bounce);
          w_state_nxt = ST_WR_STEP;
        end
      end

      ST_WR_STEP: begin
        if (r_cs) begin
          if (!avm_waitrequest) begin
            w_cs_nxt = 1'b0;
            if (stop) begin
              w_state_nxt = ST_WR_CLEAR;
            end else begin
              w_state_nxt = ST_RUN;
              w_tick_load = 1'b1;
            end
          end
        end else if (stop) begin
          w_state_nxt = ST_WR_CLEAR;
        end else begin
          // pos is committed together with the strobe that shows it
          w_cs_nxt      = 1'b1;
          w_wr_nxt.addr = PIO_ADDR_DATA;
          w_wr_nxt.data = AVM_DATA_W'(w_onehot);
          w_pos_nxt     = r_step.pos;
          w_dir_nxt     = r_step.dir;
        end
      end

      ST_WR_CLEAR: begin
        if (r_cs) begin
          if (!avm_waitrequest) begin
            w_cs_nxt    = 1'b0;
            w_state_nxt = ST_IDLE;
            w_tick_clr  = 1'b1;
          end
        end else begin
          w_cs_nxt      = 1'b1;
          w_wr_nxt.addr = PIO_ADDR_CLR;
          w_wr_nxt.data = AVM_DATA_W'(LED_ALL);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = 1'b0;
      end
    endcase
  end

  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_write_n;
  assign avm_address    = r_wr.addr;
  assign avm_writedata  = r_wr.data;
  assign busy           = r_busy;
  assign pos            = r_pos;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// Self-checking bench for led_chaser_ctrl with TICK_CYCLES=4.
module tb_led_chaser_ctrl;

  localparam int TICK = 4;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [1:0]  speed;
  logic        bounce;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        busy;
  logic [2:0]  pos;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Completed writes seen on the bus
  logic [2:0]  q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  logic [2:0]  q_pos[$];
  logic        q_busy[$];

  led_chaser_ctrl #(.TICK_CYCLES(TICK), .LED_W(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .stop            (stop),
    .speed           (speed),
    .bounce          (bounce),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .pos             (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && avm_chipselect && !avm_write_n && !avm_waitrequest) begin
      q_addr.push_back(avm_address);
      q_data.push_back(avm_writedata);
      q_cyc.push_back(cyc);
      q_pos.push_back(pos);
      q_busy.push_back(busy);
    end
  end

  // Reference: LED index of the k-th write of a run (k=0 is the initial write)
  function automatic int model_pos(input int k, input bit bnc);
    int p;
    if (!bnc) return k % 8;
    p = k % 14;
    return (p <= 7) ? p : 14 - p;
  endfunction

  task automatic clear_q();
    q_addr.delete(); q_data.delete(); q_cyc.delete(); q_pos.delete(); q_busy.delete();
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int b;
    b = budget;
    while (q_addr.size() < n && b > 0) begin
      @(posedge clk);
      b--;
    end
    #1;
    ok = (q_addr.size() >= n);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_writes: got %0d writes, required %0d", q_addr.size(), n);
    end
  endtask

  task automatic pulse_start(output int sc);
    @(posedge clk); #1;
    start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; speed = 2'd0; bounce = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, busy, pos} !==
        {1'b0, 1'b1, 3'd0, 32'd0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got cs=%b wn=%b addr=%0d data=%0h busy=%b pos=%0d, required cs=0 wn=1 addr=0 data=0 busy=0 pos=0",
               avm_chipselect, avm_write_n, avm_address, avm_writedata, busy, pos);
    end
    reset_n = 1'b1;
    clear_q();
    repeat (100) @(posedge clk);
    #1;
    n_tests++;
    if (q_addr.size() !== 0 || busy !== 1'b0 || avm_chipselect !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_write: got writes=%0d busy=%b cs=%b, required 0 0 0",
               q_addr.size(), busy, avm_chipselect);
    end
  endtask

  // One full run: start, nsteps step writes, stop, clear; checks against the model
  task automatic run_seq(input bit bnc, input logic [1:0] spd, input int nsteps);
    int sc, per, ep;
    bit ok;
    logic [31:0] ed;
    clear_q();
    bounce = bnc; speed = spd;
    repeat ($urandom_range(0, 5)) @(posedge clk);
    per = (TICK << spd) + 2;
    pulse_start(sc);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    wait_writes(nsteps + 1, (nsteps + 2) * per + 20, ok);
    stop = 1'b1;
    wait_writes(nsteps + 2, 10, ok);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_after_clear: got %b, required 0", busy);
    end
    stop = 1'b0;
    n_tests++;
    if (q_addr.size() != nsteps + 2) begin
      n_fail++; $display("FAIL write_count: got %0d, required %0d", q_addr.size(), nsteps + 2);
    end
    for (int k = 0; k < q_addr.size(); k++) begin
      if (k <= nsteps) begin
        ep = model_pos(k, bnc);
        ed = 32'd1 << ep;
        n_tests++;
        if (q_addr[k] !== 3'd0 || q_data[k] !== ed) begin
          n_fail++;
          $display("FAIL step%0d_write: got addr=%0d data=%0h, required addr=0 data=%0h (bounce=%0b)",
                   k, q_addr[k], q_data[k], ed, bnc);
        end
        n_tests++;
        if (q_pos[k] !== 3'(ep)) begin
          n_fail++; $display("FAIL step%0d_pos: got %0d, required %0d", k, q_pos[k], ep);
        end
        n_tests++;
        if (k == 0) begin
          if (q_cyc[0] - sc != 2) begin
            n_fail++; $display("FAIL init_latency: got %0d, required 2", q_cyc[0] - sc);
          end
        end else if (q_cyc[k] - q_cyc[k-1] != per) begin
          n_fail++;
          $display("FAIL step%0d_spacing: got %0d, required %0d", k, q_cyc[k] - q_cyc[k-1], per);
        end
      end else begin
        n_tests++;
        if (q_addr[k] !== 3'd5 || q_data[k] !== 32'hFF || q_busy[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_write: got addr=%0d data=%0h busy=%b, required addr=5 data=ff busy=1",
                   q_addr[k], q_data[k], q_busy[k]);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    run_seq(1'b0, 2'd0, 8);
  endtask

  task automatic test_bounce();
    run_seq(1'b1, 2'd0, 15);
  endtask

  task automatic test_speed();
    run_seq(1'b0, 2'd2, 3);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      run_seq(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(2, 16)));
  endtask

  // Speed change mid-interval applies to the following interval; a start edge while busy does nothing
  task automatic test_speed_change();
    int sc;
    bit ok;
    clear_q();
    bounce = 1'b0; speed = 2'd0;
    pulse_start(sc);
    wait_writes(2, 40, ok);
    repeat (2) @(posedge clk);
    #1;
    speed = 2'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_writes(4, 80, ok);
    stop = 1'b1;
    wait_writes(5, 10, ok);
    stop = 1'b0; speed = 2'd0;
    n_tests++;
    if (q_addr.size() != 5) begin
      n_fail++; $display("FAIL speedchg_count: got %0d, required 5", q_addr.size());
    end else begin
      n_tests++;
      if (q_cyc[2] - q_cyc[1] != 6 || q_cyc[3] - q_cyc[2] != 18) begin
        n_fail++;
        $display("FAIL speedchg_spacing: got %0d,%0d required 6,18", q_cyc[2] - q_cyc[1], q_cyc[3] - q_cyc[2]);
      end
      n_tests++;
      if (q_data[2] !== 32'h4 || q_data[3] !== 32'h8 || q_addr[4] !== 3'd5) begin
        n_fail++;
        $display("FAIL speedchg_data: got %0h,%0h,addr%0d required 4,8,addr5", q_data[2], q_data[3], q_addr[4]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_stop_waitrequest();
    int sc, s, b;
    bit ok;
    clear_q();
    bounce = 1'b0; speed = 2'd0;
    pulse_start(sc);
    wait_writes(3, 60, ok);
    avm_waitrequest = 1'b1;
    b = 50;
    while (!avm_chipselect && b > 0) begin
      @(posedge clk); #1; b--;
    end
    n_tests++;
    if (avm_chipselect !== 1'b1) begin
      n_fail++; $display("FAIL stall_strobe_seen: got cs=%b, required 1", avm_chipselect);
    end
    s = cyc;
    stop = 1'b1;
    repeat (3) begin
      n_tests++;
      if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 3'd0 || avm_writedata !== 32'h8) begin
        n_fail++;
        $display("FAIL stall_hold: got cs=%b wn=%b addr=%0d data=%0h, required 1 0 0 8",
                 avm_chipselect, avm_write_n, avm_address, avm_writedata);
      end
      @(posedge clk); #1;
    end
    avm_waitrequest = 1'b0;
    wait_writes(5, 10, ok);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_busy_fall: got %b, required 0", busy);
    end
    stop = 1'b0;
    n_tests++;
    if (q_addr.size() != 5) begin
      n_fail++; $display("FAIL stall_count: got %0d, required 5", q_addr.size());
    end else begin
      n_tests++;
      if (q_data[3] !== 32'h8 || q_cyc[3] != s + 3) begin
        n_fail++;
        $display("FAIL stall_step_done: got data=%0h cyc=+%0d, required data=8 cyc=+3", q_data[3], q_cyc[3] - s);
      end
      n_tests++;
      if (q_addr[4] !== 3'd5 || q_data[4] !== 32'hFF || q_cyc[4] - q_cyc[3] > 2) begin
        n_fail++;
        $display("FAIL stall_clear: got addr=%0d data=%0h gap=%0d, required addr=5 data=ff gap<=2",
                 q_addr[4], q_data[4], q_cyc[4] - q_cyc[3]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_start_stop_together();
    clear_q();
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL startstop_busy: got %b, required 0", busy);
    end
    start = 1'b0; stop = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (q_addr.size() !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL startstop_nowrite: got writes=%0d busy=%b, required 0 0", q_addr.size(), busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int sc, b;
    bit ok;
    clear_q();
    bounce = 1'b0; speed = 2'd0;
    pulse_start(sc);
    wait_writes(2, 40, ok);
    avm_waitrequest = 1'b1;
    b = 50;
    while (!avm_chipselect && b > 0) begin
      @(posedge clk); #1; b--;
    end
    n_tests++;
    if (avm_chipselect !== 1'b1) begin
      n_fail++; $display("FAIL rst_strobe_seen: got cs=%b, required 1", avm_chipselect);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || busy !== 1'b0 || pos !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_async_drop: got cs=%b wn=%b busy=%b pos=%0d, required 0 1 0 0",
               avm_chipselect, avm_write_n, busy, pos);
    end
    avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_q();
    repeat (30) @(posedge clk);
    #1;
    n_tests++;
    if (q_addr.size() !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle_after: got writes=%0d busy=%b, required 0 0", q_addr.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_bounce();
    test_speed();
    test_speed_change();
    test_stop_waitrequest();
    test_start_stop_together();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
